// File: rtl/ram_1r1w_param_if.sv
// Port bundle for ram_1r1w_param: read/write/clear requests and read data/busy.
// Parameters AW and DW must match those of the RAM instance.
interface ram_1r1w_param_if #(
    parameter int AW = 9,
    parameter int DW = 64
);
    localparam int MW = DW / 8;

    logic [AW-1:0] raddr;
    logic          re;
    logic [DW-1:0] rd;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wr;
    logic [MW-1:0] wmask;
    logic          we;
    logic          clr;
    logic          busy;

    // Handshake: busy acts as the inverted ready. re/we are accepted only on a
    // posedge where busy is low and are dropped (not queued) otherwise. clr is
    // accepted on every posedge. An accepted re presents rd after that same edge.
    modport master (
        output raddr, re, waddr, wr, wmask, we, clr,
        input  rd, busy
    );

    modport slave (
        input  raddr, re, waddr, wr, wmask, we, clr,
        output rd, busy
    );
endinterface

// File: rtl/ram_1r1w_param.sv
// 1R1W synchronous RAM with byte write mask and a clear engine that zeroes every
// entry after reset or on clr. Define RAM_RD_BYPASS_EN for write-to-read bypass.
module ram_1r1w_param #(
    parameter int AW = 9,
    parameter int DW = 64
) (
    input  logic           clk,
    input  logic           rst,
    ram_1r1w_param_if.slave bus,
    output logic [0:0]     o_dbg_state,
    output logic [AW-1:0]  o_dbg_clr_cnt
);
    localparam int MW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;
    logic          w_busy;
    logic          w_clr_we;
    logic          w_port_re;
    logic          w_port_we;
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // A clr seen in CLEAR restarts the sweep; the entry under the counter is still zeroed.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy        = 1'b0;
        w_clr_we      = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_busy   = 1'b1;
                w_clr_we = 1'b1;
                if (bus.clr) begin
                    w_clr_cnt_nxt = '0;
                end else if (r_clr_cnt == {AW{1'b1}}) begin
                    w_state_nxt   = S_IDLE;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.clr) begin
                    w_state_nxt   = S_CLEAR;
                    w_clr_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt   = S_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    assign w_port_re = bus.re & ~w_busy;
    assign w_port_we = bus.we & ~w_busy & (|bus.wmask);

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_port_we) begin
            for (int i = 0; i < MW; i++) begin
                if (bus.wmask[i]) begin
                    r_mem[bus.waddr][8*i +: 8] <= bus.wr[8*i +: 8];
                end
            end
        end
    end

    // Array read captures pre-write contents of the same edge (read-first).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_raw <= '0;
        end else if (w_port_re) begin
            r_rd_raw <= r_mem[bus.raddr];
        end
    end

`ifdef RAM_RD_BYPASS_EN
    logic [DW-1:0] w_wmask_bits;
    logic          r_byp_hit;
    logic [DW-1:0] r_byp_data;
    logic [DW-1:0] r_byp_bits;

    always_comb begin
        w_wmask_bits = '0;
        for (int i = 0; i < MW; i++) begin
            w_wmask_bits[8*i +: 8] = {8{bus.wmask[i]}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byp_hit  <= 1'b0;
            r_byp_data <= '0;
            r_byp_bits <= '0;
        end else if (w_port_re) begin
            r_byp_hit  <= w_port_we && (bus.waddr == bus.raddr);
            r_byp_data <= bus.wr;
            r_byp_bits <= w_wmask_bits;
        end
    end

    assign bus.rd = r_byp_hit ? ((r_byp_data & r_byp_bits) | (r_rd_raw & ~r_byp_bits))
                              : r_rd_raw;
`else
    assign bus.rd = r_rd_raw;
`endif

    assign bus.busy      = w_busy;
    assign o_dbg_state   = r_state;
    assign o_dbg_clr_cnt = r_clr_cnt;
endmodule
